// File: rtl/n2r_row_packer.sv
// n2r_row_packer: packs a narrow row-major element stream into full-width rows
// through a two-bank ping-pong row store, so one row can fill while the other drains.
// Optional build macro: N2R_PACK_ERRCHK_EN enables s_last framing checks on err.
// ROW must be at least 2 so that out_row_idx has a non-zero width.
module n2r_row_packer #(
  parameter  int WIDTH         = 16,
  parameter  int ROW           = 256,
  parameter  int COL           = 64,
  parameter  int IN_ELEMS      = 4,
  localparam int BEATS_PER_ROW = COL / IN_ELEMS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH*IN_ELEMS-1:0] s_data,
  input  logic                      s_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*COL-1:0]      out_row,
  output logic [$clog2(ROW)-1:0]    out_row_idx,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err
);

  localparam int BCW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int IW  = $clog2(ROW);
  localparam int BEAT_BITS = WIDTH * IN_ELEMS;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH*COL-1:0] bank [2];
  logic [1:0]           full;
  logic                 wp;
  logic                 rp;
  logic [BCW-1:0]       bcnt;
  logic [IW-1:0]        rin;
  logic [IW-1:0]        row_idx;

  logic       accept;
  logic       drain;
  logic       row_end;
  logic       last_beat;
  logic       frame_end;
  logic       arm;
  logic [1:0] drain_mask;

  // Handshake decode and status outputs
  always_comb begin
    s_ready     = (state == PACK) && !full[wp];
    accept      = s_valid && s_ready;
    drain       = full[rp] && out_ready;
    row_end     = accept && (bcnt == BCW'(BEATS_PER_ROW - 1));
    last_beat   = (bcnt == BCW'(BEATS_PER_ROW - 1)) && (rin == IW'(ROW - 1));
    frame_end   = accept && last_beat;
    arm         = (state == IDLE) && start;
    drain_mask  = '0;
    drain_mask[rp] = drain;
    out_valid   = full[rp];
    out_row     = bank[rp];
    out_row_idx = row_idx;
    busy        = (state != IDLE);
    frame_done  = (state == DONE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; FLUSH looks ahead at this cycle's drain so DONE lands
  // in the cycle immediately after the final row handoff
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = PACK;
      PACK:  if (frame_end) state_next = FLUSH;
      FLUSH: if ((full & ~drain_mask) == 2'b00) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row store: beat writes into bank[wp], row handoff from bank[rp]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank[0] <= '0;
      bank[1] <= '0;
      full    <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      bcnt    <= '0;
      rin     <= '0;
      row_idx <= '0;
    end else if (arm) begin
      full    <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      bcnt    <= '0;
      rin     <= '0;
      row_idx <= '0;
    end else begin
      if (accept) begin
        for (int unsigned b = 0; b < BEATS_PER_ROW; b++) begin
          if (bcnt == BCW'(b)) begin
            bank[wp][WIDTH*COL-1-b*BEAT_BITS -: BEAT_BITS] <= s_data;
          end
        end
        if (row_end) begin
          full[wp] <= 1'b1;
          wp       <= ~wp;
          bcnt     <= '0;
          rin      <= rin + 1'b1;
        end else begin
          bcnt     <= bcnt + 1'b1;
        end
      end
      if (drain) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
        row_idx  <= (row_idx == IW'(ROW - 1)) ? '0 : row_idx + 1'b1;
      end
    end
  end

`ifdef N2R_PACK_ERRCHK_EN
  // Sticky framing error: s_last must be set on exactly the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && (s_last != last_beat)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_n2r_row_packer.sv
// tb_n2r_row_packer: randomized self-checking bench for n2r_row_packer using a
// row-queue occupancy model (ROW=4, COL=8, IN_ELEMS=4, WIDTH=16).
module tb_n2r_row_packer;

  localparam int W   = 16;
  localparam int R   = 4;
  localparam int C   = 8;
  localparam int IE  = 4;
  localparam int BPR = C / IE;
  localparam int TOT = R * BPR;
  localparam int RW  = W * C;
  localparam int BW  = W * IE;
  localparam int IW  = $clog2(R);

`ifdef N2R_PACK_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef logic [RW-1:0] val_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_row;
  logic [IW-1:0] out_row_idx;
  logic          busy;
  logic          frame_done;
  logic          err;

  n2r_row_packer #(
    .WIDTH(W),
    .ROW(R),
    .COL(C),
    .IN_ELEMS(IE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_row_idx(out_row_idx),
    .busy(busy),
    .frame_done(frame_done),
    .err(err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  // Model: 0 idle, 1 packing, 2 flushing, 3 done
  int   phase = 0;
  int   beats = 0;
  int   cur_n = 0;
  val_t cur = '0;
  val_t rowq[$];
  int   m_idx = 0;
  bit   m_err = 1'b0;
  int   done_cnt = 0;

  task automatic check_val(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic val_t b2v(input logic b);
    return val_t'(b);
  endfunction

  task automatic model_reset();
    rowq.delete();
    beats = 0;
    cur_n = 0;
    cur   = '0;
    m_idx = 0;
  endtask

  task automatic check_reset_values();
    check_val("rst_s_ready", b2v(s_ready), '0);
    check_val("rst_out_valid", b2v(out_valid), '0);
    check_val("rst_out_row", out_row, '0);
    check_val("rst_out_row_idx", val_t'(out_row_idx), '0);
    check_val("rst_busy", b2v(busy), '0);
    check_val("rst_frame_done", b2v(frame_done), '0);
    check_val("rst_err", b2v(err), '0);
  endtask

  task automatic check_outputs();
    check_val("busy", b2v(busy), b2v(phase != 0));
    check_val("frame_done", b2v(frame_done), b2v(phase == 3));
    check_val("s_ready", b2v(s_ready), b2v(phase == 1 && rowq.size() < 2));
    check_val("out_valid", b2v(out_valid), b2v(rowq.size() > 0));
    check_val("err", b2v(err), b2v(m_err));
    if (rowq.size() > 0) begin
      check_val("out_row", out_row, rowq[0]);
      check_val("out_row_idx", val_t'(out_row_idx), val_t'(m_idx));
    end
    if (frame_done) done_cnt++;
  endtask

  // One clock: predict handshakes from the model, advance, then compare
  task automatic cycle();
    bit acc, drn, st, lastb, sl;
    int pre;
    logic [BW-1:0] d;
    acc   = s_valid && (phase == 1) && (rowq.size() < 2);
    drn   = out_ready && (rowq.size() > 0);
    st    = start && (phase == 0);
    lastb = (beats == TOT - 1);
    pre   = phase;
    d     = s_data;
    sl    = s_last;
    @(posedge clk);
    #1;
    if (drn) begin
      void'(rowq.pop_front());
      m_idx = (m_idx + 1) % R;
    end
    if (acc) begin
      if (ERRCHK && (sl != lastb)) m_err = 1'b1;
      cur = (cur << BW) | val_t'(d);
      cur_n++;
      if (cur_n == BPR) begin
        rowq.push_back(cur);
        cur   = '0;
        cur_n = 0;
      end
      beats++;
    end
    case (pre)
      0: if (st) begin
           phase = 1;
           model_reset();
         end
      1: if (acc && lastb) phase = 2;
      2: if (rowq.size() == 0) phase = 3;
      default: phase = 0;
    endcase
    check_outputs();
  endtask

  // vmode: 0 always valid, 1 random valid
  // rmode: 0 ready high, 1 ready low until hold, 2 toggle, 3 random
  task automatic drive(input int vmode, input int rmode, input int hold,
                       input bit seq, input int bad, input int midstart, input int cyc);
    start = (cyc == midstart);
    if (phase == 1 && beats < TOT) begin
      s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (seq) begin
        for (int k = 0; k < IE; k++) s_data[BW-1-k*W -: W] = W'(beats * IE + k);
      end else begin
        s_data = BW'({$urandom(), $urandom()});
      end
      s_last = (beats == TOT - 1) ^ (beats == bad);
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc >= hold);
      2: out_ready = 1'(cyc % 2);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_frame(input int vmode, input int rmode, input int hold,
                           input bit seq, input int bad, input int midstart);
    done_cnt = 0;
    s_valid  = 1'b0;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && phase != 0; cyc++) begin
      drive(vmode, rmode, hold, seq, bad, midstart, cyc);
      cycle();
    end
    start     = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    out_ready = 1'b0;
    check_val("frame_end_busy", b2v(busy), '0);
    check_val("done_pulses", val_t'(done_cnt), val_t'(1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Basic frame with sequential element values
    run_frame(0, 0, 0, 1'b1, -1, -1);
    // Backpressure: downstream stalled for a while
    run_frame(0, 1, 15, 1'b0, -1, -1);
    // Fill and drain overlapping, out_ready toggling
    run_frame(0, 2, 0, 1'b0, -1, -1);

    // Reset mid-frame after three accepted beats
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
      drive(0, 1, 100, 1'b1, -1, -1, cyc);
      cycle();
    end
    check_val("beats_before_reset", val_t'(beats), val_t'(3));
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    phase = 0;
    m_err = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, 0, 0, 1'b1, -1, -1);

    // Start pulse while busy must be ignored
    run_frame(1, 3, 0, 1'b0, -1, 3);
    // Framing error on beat 5 of 8, then a clean frame keeps err sticky
    run_frame(0, 0, 0, 1'b1, 4, -1);
    run_frame(1, 3, 0, 1'b0, -1, -1);
    // Random traffic
    for (int f = 0; f < 3; f++) run_frame(1, 3, 0, 1'b0, -1, -1);

    // Reset clears the sticky error
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    m_err = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n2r_row_packer.md
# n2r_row_packer

Upstream feeder for the weight-side normal-to-ready buffer. It accepts a narrow valid/ready stream of row-major matrix elements, IN_ELEMS per beat, and assembles each group of COL elements into one full-width row. Completed rows are presented to the downstream stage one per handshake, element order preserved with column 0 at the MSB. A two-bank ping-pong row store lets packing of row r+1 overlap with draining of row r.

## Interface
- WIDTH, 16, element width in bits.
- ROW, 256, rows per frame (matrix).
- COL, 64, elements per row.
- IN_ELEMS, 4, elements per input beat; COL must be a multiple of IN_ELEMS.
- BEATS_PER_ROW, COL/IN_ELEMS, derived; not to be overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that arms a new frame; ignored unless idle.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  WIDTH*IN_ELEMS  beat payload; lane k (k=0 is the earliest column) at s_data[WIDTH*IN_ELEMS-1-k*WIDTH -: WIDTH].
- s_last  in  1  marks the final beat of the frame (checked only with N2R_PACK_ERRCHK_EN).
- out_valid  out  1  full row present on out_row.
- out_ready  in  1  downstream accepts the row.
- out_row  out  WIDTH*COL  packed row; column c at [WIDTH*COL-1-c*WIDTH -: WIDTH].
- out_row_idx  out  $clog2(ROW)  index of the row on out_row, 0..ROW-1.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the last row has been handed off.
- err  out  1  sticky framing error.

## Operation
- FSM states: IDLE, PACK, FLUSH, DONE.
  - IDLE -> PACK on start.
  - PACK -> FLUSH on acceptance of beat ROW*BEATS_PER_ROW-1.
  - FLUSH -> DONE when both banks are empty.
  - DONE -> IDLE unconditionally after one cycle.
- Row store: bank[0..1], each WIDTH*COL bits, with per-bank full flag, write pointer wp, read pointer rp, beat counter bcnt (0..BEATS_PER_ROW-1), row-in counter rin.
- s_ready = (state==PACK) && !full[wp].
- Beat accept writes lanes into bank[wp] at columns bcnt*IN_ELEMS+k. On bcnt==BEATS_PER_ROW-1: set full[wp], toggle wp, clear bcnt, increment rin.
- out_valid = full[rp]; out_row = bank[rp].
- On out_valid && out_ready: clear full[rp], toggle rp, increment out_row_idx. out_row_idx wraps to 0 after ROW-1.
- Filling one bank and draining the other in the same cycle is legal. Both updates take effect.
- Accept and drain can never hit the same bank, because accept requires !full[wp].
- start while busy: ignored, no state change.
- Entry to PACK from IDLE clears bcnt, rin, wp, rp, out_row_idx, and the full flags. err is cleared only by rst_n.
- Unused bank contents are not cleared. out_row is a don't-care while out_valid=0, except after reset.

## Timing
- Reset values: s_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, frame_done=0, err=0, state=IDLE. All banks are zero.
- Reset is asynchronous. Asserting it mid-frame discards partial and full rows immediately. The next frame requires a new start.
- start accepted at edge t: busy=1 and s_ready=1 from t+1.
- Latency: a row's last beat accepted at edge t gives out_valid=1 from t+1.
- Throughput: with out_ready held 1, s_ready never deasserts inside a frame, for any BEATS_PER_ROW>=1.
- Backpressure: with out_ready=0, at most 2 rows are buffered. s_ready drops the cycle after the second row completes.
- frame_done is high for exactly the DONE cycle: the cycle after the final row handoff.

## Configuration
- N2R_PACK_ERRCHK_EN defined: the block checks s_last on every accepted beat. err is set (sticky) if s_last=1 on any beat other than the frame's final beat, or s_last=0 on the final beat. Data flow is unaffected by err.
- N2R_PACK_ERRCHK_EN undefined: s_last is ignored, err is tied 0, and no checking logic is built.

## Test plan
All scenarios use ROW=4, COL=8, IN_ELEMS=4, WIDTH=16 unless stated.
- Basic frame: start, then 8 back-to-back beats of values 0..31 with out_ready=1.
  - Rows appear on cycles 2, 4, 6, 8 after the first beat.
  - Row 0 MSB element = 0x0000, LSB element = 0x0007.
  - out_row_idx = 0, 1, 2, 3; frame_done pulses once; s_ready stays 1.
- Backpressure: out_ready=0 throughout the frame.
  - s_ready falls after beat 4 (2 rows stored) and stays 0.
  - Releasing out_ready drains row 0 then row 1, with no data loss.
- Simultaneous fill and drain: out_ready toggles every cycle with s_valid=1 continuously.
  - All 4 rows arrive intact and in order.
  - No cycle has both banks' full flags clear while s_ready=0.
- Reset mid-op: assert rst_n=0 after beat 3.
  - All outputs equal their reset values asynchronously.
  - A new start then produces a clean frame starting at out_row_idx=0.
- Start while busy: pulse start mid-frame; there is no effect on counters or data.
- Framing check (with N2R_PACK_ERRCHK_EN): s_last=1 on beat 5 of 8.
  - err=1 from the next cycle and stays set through DONE and subsequent frames until rst_n.
  - Rows are still correct.
  - Without the macro, err stays 0.
